// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one external combinational ALU between two requesters. A request is
// accepted in IDLE, its operands are latched and presented to the ALU for one
// EXEC cycle, and the ALU result/zero flag are captured and held on the
// owner's response channel until that requester takes them.
//
// Ports
//   clock, resetn            : clock, asynchronous active-low reset
//   reqN_valid/ready         : request handshake (N = 0, 1)
//   reqN_a, reqN_b, reqN_aluc: operands and ALU control code
//   rspN_valid/ready         : response handshake
//   rspN_s, rspN_z           : result and zero flag (0 when not owner)
//   alu_a, alu_b, alu_aluc   : registered ALU inputs
//   alu_s, alu_z             : ALU outputs
//   busy                     : high whenever the arbiter is not IDLE
//
// Build option
//   ALU_ARB_RR_EN defined   : round-robin arbitration between requesters
//   ALU_ARB_RR_EN undefined : fixed priority, requester 0 wins ties
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_aluc,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_s,
  output logic             rsp0_z,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_aluc,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_s,
  output logic             rsp1_z,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_aluc,
  input  logic [WIDTH-1:0] alu_s,
  input  logic             alu_z,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       aluc_q, aluc_d;
  logic             rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [WIDTH-1:0] rsp0_s_q, rsp0_s_d, rsp1_s_q, rsp1_s_d;
  logic             rsp0_z_q, rsp0_z_d, rsp1_z_q, rsp1_z_d;
  logic             busy_q, busy_d;

  logic             prio1_s;   // requester 1 wins a tie
  logic             grant1_s;  // requester 1 is the current winner
  logic             accept_s;
  logic             rsp_hs_s;

`ifdef ALU_ARB_RR_EN
  logic ptr_q, ptr_d;
  assign prio1_s = ptr_q;

  // Pointer moves to the requester that was not just granted.
  always_comb begin
    ptr_d = ptr_q;
    if (accept_s) begin
      ptr_d = ~grant1_s;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register; starts favouring requester 0.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign prio1_s = 1'b0;
`endif

  // Requester 1 wins when alone, or on a tie when it holds priority.
  assign grant1_s   = req1_valid && (!req0_valid || prio1_s);
  assign req0_ready = (state_q == IDLE) && req0_valid && !grant1_s;
  assign req1_ready = (state_q == IDLE) && grant1_s;
  assign accept_s   = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign rsp_hs_s   = (state_q == RESP) &&
                      (owner_q ? (rsp1_valid_q && rsp1_ready) : (rsp0_valid_q && rsp0_ready));

  // Next-state, operand latch and response register logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    a_d          = a_q;
    b_d          = b_q;
    aluc_d       = aluc_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp0_s_d     = rsp0_s_q;
    rsp0_z_d     = rsp0_z_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp1_s_d     = rsp1_s_q;
    rsp1_z_d     = rsp1_z_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          owner_d = grant1_s;
          a_d     = grant1_s ? req1_a    : req0_a;
          b_d     = grant1_s ? req1_b    : req0_b;
          aluc_d  = grant1_s ? req1_aluc : req0_aluc;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        // Capture the ALU outputs only on the owner's port; the other stays 0.
        if (owner_q) begin
          rsp1_valid_d = 1'b1;
          rsp1_s_d     = alu_s;
          rsp1_z_d     = alu_z;
        end else begin
          rsp0_valid_d = 1'b1;
          rsp0_s_d     = alu_s;
          rsp0_z_d     = alu_z;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_hs_s) begin
          rsp0_valid_d = 1'b0;
          rsp0_s_d     = {WIDTH{1'b0}};
          rsp0_z_d     = 1'b0;
          rsp1_valid_d = 1'b0;
          rsp1_s_d     = {WIDTH{1'b0}};
          rsp1_z_d     = 1'b0;
          state_d      = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, operand and response registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      a_q          <= {WIDTH{1'b0}};
      b_q          <= {WIDTH{1'b0}};
      aluc_q       <= 4'd0;
      rsp0_valid_q <= 1'b0;
      rsp0_s_q     <= {WIDTH{1'b0}};
      rsp0_z_q     <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp1_s_q     <= {WIDTH{1'b0}};
      rsp1_z_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      aluc_q       <= aluc_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_s_q     <= rsp0_s_d;
      rsp0_z_q     <= rsp0_z_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_s_q     <= rsp1_s_d;
      rsp1_z_q     <= rsp1_z_d;
      busy_q       <= busy_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_aluc   = aluc_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_s     = rsp0_s_q;
  assign rsp0_z     = rsp0_z_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_s     = rsp1_s_q;
  assign rsp1_z     = rsp1_z_q;
  assign busy       = busy_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares a single combinational `alu` instance between two requesters (e.g. the main datapath and a branch/address helper) in a DE2 multi-cycle computer variant. It arbitrates ALU requests, latches the winning operands, and drives the ALU from registers for exactly one cycle. It then captures the ALU outputs `s` and `z` and returns them to the owning requester through a valid/ready response channel. It contains no arithmetic of its own; all operations are performed by the attached `alu`.

## Interface
- `WIDTH`, 32: operand/result width; fixed at 32 to match `alu`.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has an operation pending.
- `req0_ready`  out  1  arbiter accepts requester 0 this cycle.
- `req0_a`, `req0_b`  in  WIDTH  operands for requester 0.
- `req0_aluc`  in  4  ALU control code for requester 0, passed to `alu` unmodified.
- `rsp0_valid`  out  1  result for requester 0 is available.
- `rsp0_ready`  in  1  requester 0 consumes the result.
- `rsp0_s`  out  WIDTH  result value for requester 0.
- `rsp0_z`  out  1  zero flag for requester 0.
- `req1_*` and `rsp1_*` are identical to the requester 0 ports, for requester 1.
- `alu_a`, `alu_b`  out  WIDTH  ALU operands, driven from registers.
- `alu_aluc`  out  4  ALU control code, driven from a register.
- `alu_s`  in  WIDTH  ALU result.
- `alu_z`  in  1  ALU zero flag.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- **States:** IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE**
  - Arbiter selects a winner among the asserted `reqN_valid`.
  - The winner's `reqN_ready` is 1 (combinational from valid and the grant). The loser's ready is 0.
  - On `valid && ready` at a rising edge:
    - latch `a`, `b`, `aluc` into the operand registers;
    - record the owner ID;
    - go to EXEC.
- **EXEC**
  - Lasts exactly one cycle. `alu_*` hold the latched operands.
  - At the next edge:
    - `alu_s` and `alu_z` are captured into the result registers;
    - `rspN_valid` of the owner is set;
    - go to RESP.
- **RESP**
  - The owner's `rspN_valid` stays 1 and `rspN_s` / `rspN_z` stay stable until `rspN_ready`.
  - On `valid && ready`: clear valid and go to IDLE.
  - No new request is accepted in the same cycle.
- **Ready outside IDLE:** both `reqN_ready` are 0 in EXEC and RESP.
- **Non-owner response port:** `rsp_valid` is 0 and `rsp_s` / `rsp_z` are 0.
- **Data path:** the ALU output is passed through untouched. An undefined `aluc` yields `s=0`, `z=1` from `alu`; the arbiter forwards this as-is.
- **Operand registers:** retain their last value in IDLE; no glitching of `alu_*` outside EXEC.
- **Reset (at any time, including mid-EXEC/RESP):**
  - state returns to IDLE;
  - pending operation discarded, requester must reissue;
  - all `rsp*_valid` = 0, `rsp*_s` = 0, `rsp*_z` = 0;
  - `alu_a` = `alu_b` = 0, `alu_aluc` = 0;
  - `busy` = 0;
  - priority pointer = requester 0.

## Timing
- Accept edge k → EXEC during cycle k..k+1 → `rspN_valid` = 1 after edge k+1. Result latency: one cycle after acceptance.
- Minimum issue interval: 3 cycles per operation (IDLE, EXEC, RESP), achieved when `rsp_ready` is held high.
- The result must be captured from `alu_s` at the end of EXEC. The ALU path must meet one full clock period, since the `aluc=4'b1011` parity operation is a deep combinational chain.
- `reqN_ready` depends combinationally only on state, the grant and the `reqN_valid`; it never depends on `rspN_ready`.
- A requester may drop `valid` before it is accepted. No request is lost or duplicated once accepted.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration.
  - The pointer favours the requester not granted last; it is updated on each accept.
  - With both requesters continuously valid, grants alternate 0,1,0,1…
  - After reset, requester 0 wins the first tie.
- `ALU_ARB_RR_EN` undefined: fixed priority. Requester 0 always wins a tie; requester 1 may starve.
- Port list is identical in both builds.

## Test plan
- **Single ADD:** `req0`: a=5, b=3, aluc=4'b0000 → `rsp0_valid` one cycle after accept; s=8, z=0; `rsp1_valid` stays 0.
- **SUB zero flag:** `req1`: a=7, b=7, aluc=4'b0100 → s=0, z=1. Also `req1`: a=32'h1, b=32'h80000000, aluc=4'b1111 → s=32'hC0000000.
- **Contention:** both valid continuously, each issuing 4 ops.
  - With `ALU_ARB_RR_EN`: grant order 0,1,0,1,0,1,0,1.
  - Without `ALU_ARB_RR_EN`: 0,0,0,0 then 1,1,1,1.
- **Backpressure:** hold `rsp0_ready`=0 for 5 cycles → `rsp0_valid`, `s` and `z` are stable; `req0_ready`=`req1_ready`=0 throughout; one cycle after ready goes high the arbiter is back in IDLE.
- **Reset mid-operation:** assert `resetn`=0 during EXEC → all outputs reach their reset values immediately without waiting for a clock edge. After release the first tie goes to requester 0, and no stale response appears.
- **Undefined code:** aluc=4'b1110, a=9, b=9 → s=0, z=1 forwarded to the owner.
